// File: rtl/and3_sweep_checker.sv
// On-chip exhaustive sweep of a 3-input AND gate: drives {w,x,y} = 0..7, samples z
// after a settle window and reports mismatches. Define AND3_SWEEP_STOP_ON_FAIL_EN to end at the first mismatch.
module and3_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  // A settle time of zero would never sample, so it is promoted to one cycle.
  localparam int         S_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0] RELOAD = 4'(S_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  state_e     state_q;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [3:0] err_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       fv_q;
  logic [2:0] ff_q;

  logic mismatch;
  logic last_sample;

  assign mismatch = z ^ (vec_q == 3'b111);

`ifdef AND3_SWEEP_STOP_ON_FAIL_EN
  assign last_sample = mismatch | (vec_q == 3'b111);
`else
  assign last_sample = (vec_q == 3'b111);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      ff_q    <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            vec_q   <= 3'd0;
            cnt_q   <= RELOAD;
            err_q   <= 4'd0;
            fv_q    <= 1'b0;
            ff_q    <= 3'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (mismatch) begin
              err_q <= err_q + 4'd1;
              if (!fv_q) begin
                ff_q <= vec_q;
                fv_q <= 1'b1;
              end
            end
            // Leaving at vector 7 takes precedence, so vec never wraps.
            if (last_sample) begin
              state_q <= DONE;
            end else begin
              vec_q <= vec_q + 3'd1;
              cnt_q <= RELOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 4'd0);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {w, x, y}  = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: doc/and3_sweep_checker.md
# and3_sweep_checker

Self-checking stimulus controller for the 3-input AND gate. On a start pulse it drives the gate's inputs w, x and y through all 8 combinations in ascending order. After a programmable settle time it samples the gate output z and compares it with the expected AND result. At the end it reports pass/fail, the mismatch count and the first failing vector. It sits beside the gate on the FPGA and replaces the hand-timed stimulus sequence with an on-chip, clocked sweep.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before z is sampled. Legal range 1..15; a value of 0 is treated as 1.
- `clk`  in  1  single system clock, all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  sweep request; sampled only in IDLE
- `z`  in  1  output of the gate under test
- `w`, `x`, `y`  out  1 each  gate inputs, registered; {w,x,y} = current vector, w is the MSB
- `busy`  out  1  high from the cycle after start is accepted until done
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  1 when the last sweep had zero mismatches; held until the next start
- `err_count`  out  4  number of mismatching vectors, 0..8
- `fail_valid`  out  1  set when at least one mismatch was recorded
- `first_fail`  out  3  vector {w,x,y} of the first mismatch; valid when fail_valid=1

## Operation
- **States:** IDLE, SETTLE, DONE.
- **Reset values:** state IDLE; w=x=y=0; busy=0; done=0; pass=0; err_count=0; fail_valid=0; first_fail=0; settle counter 0.
- **IDLE, start=1:**
  - vec←0 and the settle counter←SETTLE_CYCLES−1.
  - err_count, fail_valid, first_fail and pass are cleared.
  - busy←1 and the state moves to SETTLE.
- **SETTLE, counter≠0:** the counter decrements.
- **SETTLE, counter=0 (sample edge):**
  - z is compared with expected = (vec==3'b111).
  - On a mismatch, err_count increments. If fail_valid=0, then first_fail←vec and fail_valid←1.
  - If vec=7, the state moves to DONE. Otherwise vec increments and the counter reloads.
- **DONE:**
  - done=1 for one cycle.
  - pass = (err_count==0) with the final sample included.
  - busy←0 and the state returns to IDLE.
- **Start handling:** start while busy or in DONE is ignored; it is not queued.
- **Arithmetic:** err_count is 4 bits. The maximum value of 8 fits, so no saturation is needed.
- **vec wrap:** vec never wraps. The transition to DONE takes precedence over the increment at vec=7.
- **Result hold:** w, x and y hold the last vector (3'b111) after the sweep until the next start. The result outputs hold until the next accepted start.

## Timing
- Start is accepted at edge E0. The vector is then held for SETTLE_CYCLES cycles; it changes at E0 + k·S for k = 1..7, where S = SETTLE_CYCLES.
- The sample for vector k is taken at edge E0 + (k+1)·S.
- done is high during the cycle after edge E0 + 8·S + 1. With the default S=2, done follows edge 17.
- busy is high from E0 through the edge at which DONE is entered. It is low in the cycle that done is high.
- z must be stable S cycles after a vector changes. It is sampled as a synchronous input with no synchronizer.
- **Reset mid-sweep:** all state returns to the reset values immediately (asynchronously). No done pulse is produced. A new start is needed afterwards.
- **Simultaneous start and DONE:** start is ignored and DONE completes normally.

## Configuration
- `AND3_SWEEP_STOP_ON_FAIL_EN` defined:
  - A mismatch at a sample edge moves the state straight to DONE. The remaining vectors are skipped.
  - The result is err_count=1, fail_valid=1 and pass=0. done follows the failing sample edge by one cycle.
- Macro undefined: all 8 vectors are always swept and every mismatch is counted.

## Test plan
- **Golden AND3 on z, S=2:** start at E0 → vectors 0..7 appear in order, two cycles each. done pulses after E17 with pass=1, err_count=0, fail_valid=0, and {w,x,y} stays at 3'b111.
- **z stuck at 0:** pass=0, err_count=1, first_fail=3'b111.
- **z stuck at 1, macro undefined:** err_count=7, first_fail=3'b000, done after E17.
- **z stuck at 1, macro defined:** err_count=1, first_fail=3'b000, done after E3.
- **z driven by OR3, S=3:** err_count=6, first_fail=3'b001, done after E25.
- **Mid-sweep events:** assert rst_n=0 mid-sweep at vec=4, expecting all outputs at reset values with no done. Pulse start again while busy, expecting it ignored and the timing unchanged.
